// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiply-accumulate datapath: FSM states,
// default widths and the saturation limits of a signed accumulator.
package booth_pkg;

  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 12;
  localparam int LEN_W_DEF  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic int ACC_MAX(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int ACC_MIN(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Combinational signed saturating adder: ACC_W accumulator plus PROD_W product,
// clamped to the accumulator range with an overflow flag.
module booth_sat_add
  import booth_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_prod,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_ovf
);

  localparam logic [ACC_W-1:0] LP_MAX = ACC_W'(ACC_MAX(ACC_W));
  localparam logic [ACC_W-1:0] LP_MIN = ACC_W'(ACC_MIN(ACC_W));

  logic [ACC_W:0] w_acc_ext;
  logic [ACC_W:0] w_prod_ext;
  logic [ACC_W:0] w_sum_wide;

  assign w_acc_ext  = {i_acc[ACC_W-1], i_acc};
  assign w_prod_ext = {{(ACC_W + 1 - PROD_W){i_prod[PROD_W-1]}}, i_prod};
  assign w_sum_wide = w_acc_ext + w_prod_ext;

  // One guard bit is enough: the two top bits disagree exactly when the
  // true sum leaves the ACC_W range, and the guard bit gives the direction.
  always_comb begin
    o_sum = w_sum_wide[ACC_W-1:0];
    o_ovf = 1'b0;
    if (w_sum_wide[ACC_W] != w_sum_wide[ACC_W-1]) begin
      o_ovf = 1'b1;
      o_sum = w_sum_wide[ACC_W] ? LP_MIN : LP_MAX;
    end
  end

endmodule

// File: rtl/booth_product_accumulator.sv
// Sums a programmable number of signed products into a saturating accumulator
// and presents each finished sum on a valid/ready result port.
module booth_product_accumulator
  import booth_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic [LEN_W-1:0]  i_cfg_len,
  input  logic              i_prod_valid,
  output logic              o_prod_ready,
  input  logic [PROD_W-1:0] i_prod_data,
  output logic              o_acc_valid,
  input  logic              i_acc_ready,
  output logic [ACC_W-1:0]  o_acc_data,
  output logic              o_acc_sat
);

  state_t             r_state;
  state_t             w_state_next;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_acc_next;
  logic               r_sat;
  logic               w_sat_next;
  logic [LEN_W-1:0]   r_remaining;
  logic [LEN_W-1:0]   w_remaining_next;

  logic [ACC_W-1:0]   w_sum;
  logic               w_ovf;
  logic [ACC_W-1:0]   w_first_acc;
  logic [LEN_W-1:0]   w_first_rem;
  logic               w_prod_hs;
  logic               w_start;

  booth_sat_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_sat_add (
    .i_acc  (r_acc),
    .i_prod (i_prod_data),
    .o_sum  (w_sum),
    .o_ovf  (w_ovf)
  );

  assign w_first_acc = {{(ACC_W - PROD_W){i_prod_data[PROD_W-1]}}, i_prod_data};
  // cfg_len==0 means 2^LEN_W products; the modular decrement yields 2^LEN_W-1.
  assign w_first_rem = i_cfg_len - LEN_W'(1);

  always_comb begin
    o_prod_ready = 1'b0;
    if (!i_clr) begin
      case (r_state)
        IDLE, ACCUM: o_prod_ready = 1'b1;
        HOLD:        o_prod_ready = i_acc_ready;
        default:     o_prod_ready = 1'b0;
      endcase
    end
  end

  assign o_acc_valid = (r_state == HOLD) && !i_clr;
  assign o_acc_data  = r_acc;
  assign o_acc_sat   = r_sat;

  assign w_prod_hs = i_prod_valid && o_prod_ready;
  // Outside ACCUM any accepted product opens a new sum (in HOLD it also
  // retires the pending result, since prod_ready there implies acc_ready).
  assign w_start   = w_prod_hs && (r_state != ACCUM);

  always_comb begin
    w_state_next     = r_state;
    w_acc_next       = r_acc;
    w_sat_next       = r_sat;
    w_remaining_next = r_remaining;

    case (r_state)
      IDLE: begin
        w_state_next = IDLE;
      end
      ACCUM: begin
        if (w_prod_hs) begin
          w_acc_next       = w_sum;
          w_sat_next       = r_sat | w_ovf;
          w_remaining_next = r_remaining - LEN_W'(1);
          if (r_remaining <= LEN_W'(1)) begin
            w_state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (i_acc_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    if (w_start) begin
      w_acc_next       = w_first_acc;
      w_sat_next       = 1'b0;
      w_remaining_next = w_first_rem;
      w_state_next     = (w_first_rem == '0) ? HOLD : ACCUM;
    end

    if (i_clr) begin
      w_state_next     = IDLE;
      w_acc_next       = '0;
      w_sat_next       = 1'b0;
      w_remaining_next = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_sat       <= 1'b0;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_next;
      r_acc       <= w_acc_next;
      r_sat       <= w_sat_next;
      r_remaining <= w_remaining_next;
    end
  end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Self-checking bench for booth_product_accumulator: directed scenarios plus
// randomized valid/ready traffic compared against a queue-based sum model.
module tb_booth_product_accumulator;

  localparam int SUM_MAX = 2047;
  localparam int SUM_MIN = -2048;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic [4:0] cfg_len = 5'd0;
  logic       prod_valid = 1'b0;
  logic       prod_ready;
  logic [7:0] prod_data = 8'd0;
  logic       acc_valid;
  logic       acc_ready = 1'b1;
  logic [11:0] acc_data;
  logic       acc_sat;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 1'b0;

  // Reference model: running sum of the current dot product, plus queue of
  // finished results awaiting retirement.
  bit m_in_sum = 1'b0;
  int m_len = 0;
  int m_cnt = 0;
  int m_sum = 0;
  bit m_sat = 1'b0;
  int q_data[$];
  bit q_sat[$];

  booth_product_accumulator dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_clr        (clr),
    .i_cfg_len    (cfg_len),
    .i_prod_valid (prod_valid),
    .o_prod_ready (prod_ready),
    .i_prod_data  (prod_data),
    .o_acc_valid  (acc_valid),
    .i_acc_ready  (acc_ready),
    .o_acc_data   (acc_data),
    .o_acc_sat    (acc_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      m_in_sum = 1'b0;
      q_data.delete();
      q_sat.delete();
    end else if (mon_en) begin
      check("mon_acc_valid", int'(acc_valid), int'(!clr && q_data.size() > 0));
      check("mon_prod_ready", int'(prod_ready),
            int'(!clr && (q_data.size() == 0 || acc_ready)));
      if (clr) begin
        m_in_sum = 1'b0;
        q_data.delete();
        q_sat.delete();
      end else begin
        if (acc_valid && acc_ready && q_data.size() > 0) begin
          check("mon_result_data", int'($signed(acc_data)), q_data[0]);
          check("mon_result_sat", int'(acc_sat), int'(q_sat[0]));
          void'(q_data.pop_front());
          void'(q_sat.pop_front());
        end
        if (prod_valid && prod_ready) begin
          if (!m_in_sum) begin
            m_len = (cfg_len == 0) ? 32 : int'(cfg_len);
            m_sum = 0;
            m_sat = 1'b0;
            m_cnt = 0;
            m_in_sum = 1'b1;
          end
          m_sum = m_sum + int'($signed(prod_data));
          if (m_sum > SUM_MAX) begin
            m_sum = SUM_MAX;
            m_sat = 1'b1;
          end else if (m_sum < SUM_MIN) begin
            m_sum = SUM_MIN;
            m_sat = 1'b1;
          end
          m_cnt++;
          if (m_cnt == m_len) begin
            q_data.push_back(m_sum);
            q_sat.push_back(m_sat);
            m_in_sum = 1'b0;
          end
        end
      end
    end
  end

  // Offers one product and returns at posedge+1 after it is accepted.
  task automatic put(input int p);
    bit done;
    done = 1'b0;
    prod_valid = 1'b1;
    prod_data  = 8'(p);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (prod_ready) begin
        done = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    prod_valid = 1'b0;
    check("put_timeout", int'(done), 1);
  endtask

  task automatic get_result(input string tag, input int exp_d, input int exp_s,
                            output int waited);
    waited = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (acc_valid) begin
        waited = k;
        break;
      end
    end
    if (waited < 0) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      check({tag, "_data"}, int'($signed(acc_data)), exp_d);
      check({tag, "_sat"}, int'(acc_sat), exp_s);
      if (acc_ready) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_acc_valid"}, int'(acc_valid), 0);
    check({tag, "_prod_ready"}, int'(prod_ready), 1);
    check({tag, "_acc_data"}, int'(acc_data), 0);
    check({tag, "_acc_sat"}, int'(acc_sat), 0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_acc_valid", int'(acc_valid), 0);
    check("rst_prod_ready", int'(prod_ready), 1);
    check("rst_acc_data", int'(acc_data), 0);
    check("rst_acc_sat", int'(acc_sat), 0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Four back-to-back products
    acc_ready = 1'b1;
    cfg_len = 5'd4;
    put(3); put(-5); put(7); put(100);
    get_result("t1", 105, 0, w);
    check("t1_latency", w, 0);

    // Single product result held under back-pressure
    acc_ready = 1'b0;
    cfg_len = 5'd1;
    put(-128);
    prod_valid = 1'b1;
    prod_data  = 8'd9;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t2_hold_valid", int'(acc_valid), 1);
      check("t2_hold_ready", int'(prod_ready), 0);
      check("t2_hold_data", int'($signed(acc_data)), -128);
    end
    @(posedge clk);
    #1;
    acc_ready = 1'b1;
    @(negedge clk);
    check("t2_release_ready", int'(prod_ready), 1);
    @(posedge clk);
    #1;
    prod_valid = 1'b0;
    get_result("t2_next", 9, 0, w);

    // Positive saturation, then a clean sum
    cfg_len = 5'd17;
    for (int k = 0; k < 17; k++) put(127);
    get_result("t3_sat", SUM_MAX, 1, w);
    cfg_len = 5'd2;
    put(1); put(1);
    get_result("t3_clean", 2, 0, w);

    // cfg_len 0 means 32 products
    cfg_len = 5'd0;
    for (int k = 0; k < 31; k++) put(-128);
    @(negedge clk);
    check("t4_not_done", int'(acc_valid), 0);
    @(posedge clk);
    #1;
    put(-128);
    get_result("t4_min", SUM_MIN, 1, w);

    // Synchronous abort mid-sum
    cfg_len = 5'd4;
    put(5); put(6);
    clr = 1'b1;
    @(negedge clk);
    check("t5_clr_ready", int'(prod_ready), 0);
    check("t5_clr_valid", int'(acc_valid), 0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    check("t5_idle_ready", int'(prod_ready), 1);
    check("t5_idle_data", int'(acc_data), 0);
    @(posedge clk);
    #1;
    cfg_len = 5'd2;
    put(10); put(20);
    get_result("t5_after", 30, 0, w);

    // Asynchronous reset mid-sum and while holding a result
    cfg_len = 5'd4;
    put(1); put(2);
    async_reset_check("t6_accum");
    acc_ready = 1'b0;
    cfg_len = 5'd1;
    put(55);
    @(negedge clk);
    check("t6_hold_valid", int'(acc_valid), 1);
    @(posedge clk);
    #1;
    async_reset_check("t6_hold");
    acc_ready = 1'b1;

    // Randomized traffic with stalls and occasional aborts
    for (int k = 0; k < 4000; k++) begin
      prod_valid = ($urandom_range(0, 3) != 0);
      prod_data  = ($urandom_range(0, 3) == 0) ? 8'd127 : 8'($urandom);
      acc_ready  = ($urandom_range(0, 2) != 0);
      clr        = ($urandom_range(0, 60) == 0);
      cfg_len    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 5));
      @(posedge clk);
      #1;
    end
    prod_valid = 1'b0;
    clr = 1'b0;
    acc_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("drain_queue", q_data.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/booth_product_accumulator.md
# booth_product_accumulator

Sequential stage directly downstream of the 4x4 Booth multiplier. It accepts a stream of signed 8-bit products over a valid/ready handshake and sums a programmable number of them (a dot-product length) into a saturating signed accumulator. It presents each finished sum on a valid/ready output port. The block turns single-cycle products into multiply-accumulate results for the filter and dot-product datapaths.

## Interface
- PROD_W, 8, product width (two's complement, matches multiplier output)
- ACC_W, 12, accumulator/result width, ACC_W > PROD_W
- LEN_W, 5, width of length field; cfg_len = 0 encodes 2^LEN_W products
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous abort; discards partial sum, returns to IDLE
- cfg_len  in  LEN_W  products per result; sampled only on first-product handshake
- prod_valid  in  1  product available
- prod_ready  out  1  block accepts product this cycle
- prod_data  in  PROD_W  signed product
- acc_valid  out  1  result available
- acc_ready  in  1  consumer takes result this cycle
- acc_data  out  ACC_W  signed saturated sum
- acc_sat  out  1  saturation occurred at least once in this result

## Operation
- FSM states: IDLE, ACCUM, HOLD.
- IDLE: prod_ready=1, acc_valid=0. On prod handshake: acc <= sign-extend(prod_data), sat <= 0, remaining <= (cfg_len==0 ? 2^LEN_W : cfg_len) - 1. If remaining would be 0, go to HOLD; else go to ACCUM.
- ACCUM: prod_ready=1. On handshake: acc <= sat_add(acc, prod_data), sat <= sat | overflow, remaining decrements. Leave for HOLD when remaining reaches 0 (that is, it was 1). With no handshake, hold state.
- HOLD: acc_valid=1 with acc_data/acc_sat stable. prod_ready = acc_ready, combinational.
  - acc_ready=1 with prod_valid=1: result retires and the product is accepted as the first of a new sum (IDLE rules, fresh cfg_len). Next state is ACCUM or HOLD.
  - acc_ready=1 with prod_valid=0: go to IDLE.
  - acc_ready=0: stay; no product accepted.
- Arithmetic: sum formed at ACC_W+1 bits.
  - Above 2^(ACC_W-1)-1: clamp to max.
  - Below -2^(ACC_W-1): clamp to min.
  - Either clamp sets sat. Clamped value continues accumulating; no wrap.
- clr: highest priority over every handshake. Next state IDLE, acc <= 0, sat <= 0, remaining <= 0. No handshake completes in a clr cycle (prod_ready and acc_valid forced 0 while clr=1).
- acc_data and acc_sat reflect internal registers in all states. They are meaningful only while acc_valid=1.

## Timing
- Reset values: state IDLE, acc_data 0, acc_sat 0, acc_valid 0, remaining 0. prod_ready is 1 after reset (IDLE).
- Latency: acc_valid rises the cycle after the last product's handshake edge.
- Throughput: one product per cycle. Back-to-back results with no bubble when acc_ready=1 in HOLD.
- acc_valid, once high, stays high with stable data until handshake, clr or reset.
- prod_ready is combinational only from state, clr and acc_ready. No path from prod_valid or prod_data.
- Reset asserted mid-sum: immediate return to reset values. Partial sum lost.

## Structure
- Shared package booth_pkg holds:
  - state enum {IDLE, ACCUM, HOLD}
  - PROD_W and ACC_W defaults
  - ACC_MAX/ACC_MIN constant functions
- Sub-module booth_sat_add: combinational signed ACC_W + PROD_W saturating adder with overflow flag. Reusable by future MAC stages.
- Top holds FSM, remaining counter, acc/sat registers and handshake logic.

## Test plan
- Reset, then cfg_len=4, products 3, -5, 7, 100 back-to-back, acc_ready=1 -> acc_data=105, acc_sat=0, acc_valid high one cycle after fourth handshake.
- cfg_len=1, product -128 -> acc_data=-128. With acc_ready low 5 cycles: acc_valid held, prod_ready=0, product 9 offered but not taken until acc_ready=1, then 9 accepted.
- cfg_len=17, seventeen products of 127 -> acc_data=2047, acc_sat=1. Next sum with cfg_len=2, products 1 and 1 -> 2, acc_sat=0.
- cfg_len=0 (32 products), all -128 -> acc_data=-2048, acc_sat=1 after the 32nd handshake only.
- cfg_len=4, two products accepted, clr pulsed one cycle -> IDLE, prod_ready=0 during clr. Following cfg_len=2, products 10, 20 -> 30.
- rst_n dropped mid-ACCUM and during HOLD -> outputs return to reset values asynchronously. Random valid/ready stalls against a reference model give matching sums.
